// File: rtl/reservation_station_if.sv
// Dispatch, wakeup and issue bundle of the reservation station.
interface reservation_station_if #(
   parameter int IQ_SIZE     = 16,
   parameter int ISSUE_PORTS = 3,
   parameter int CDB_PORTS   = 3,
   parameter int DATA_W      = 32,
   parameter int TAG_W       = 6,
   parameter int ROB_W       = 6,
   parameter int OP_W        = 5
);
   localparam int OCC_W = $clog2(IQ_SIZE + 1);

   logic                          flush;
   logic                          disp_valid;
   logic                          disp_ready;
   logic [OP_W-1:0]               disp_op;
   logic [TAG_W-1:0]              disp_rd_tag;
   logic [ROB_W-1:0]              disp_rob;
   logic [TAG_W-1:0]              disp_rs1_tag;
   logic [TAG_W-1:0]              disp_rs2_tag;
   logic                          disp_rs1_rdy;
   logic                          disp_rs2_rdy;
   logic [DATA_W-1:0]             disp_rs1_data;
   logic [DATA_W-1:0]             disp_rs2_data;
   logic [CDB_PORTS-1:0]          cdb_valid;
   logic [CDB_PORTS*TAG_W-1:0]    cdb_tag;
   logic [CDB_PORTS*DATA_W-1:0]   cdb_data;
   logic [ISSUE_PORTS-1:0]        fu_ready;
   logic [ISSUE_PORTS-1:0]        iss_valid;
   logic [ISSUE_PORTS*OP_W-1:0]   iss_op;
   logic [ISSUE_PORTS*DATA_W-1:0] iss_rs1;
   logic [ISSUE_PORTS*DATA_W-1:0] iss_rs2;
   logic [ISSUE_PORTS*TAG_W-1:0]  iss_rd_tag;
   logic [ISSUE_PORTS*ROB_W-1:0]  iss_rob;
   logic [OCC_W-1:0]              occupancy;

   modport slave (
      input  flush, disp_valid, disp_op, disp_rd_tag, disp_rob,
      input  disp_rs1_tag, disp_rs2_tag, disp_rs1_rdy, disp_rs2_rdy,
      input  disp_rs1_data, disp_rs2_data,
      input  cdb_valid, cdb_tag, cdb_data, fu_ready,
      output disp_ready, iss_valid, iss_op, iss_rs1, iss_rs2,
      output iss_rd_tag, iss_rob, occupancy
   );

   modport master (
      output flush, disp_valid, disp_op, disp_rd_tag, disp_rob,
      output disp_rs1_tag, disp_rs2_tag, disp_rs1_rdy, disp_rs2_rdy,
      output disp_rs1_data, disp_rs2_data,
      output cdb_valid, cdb_tag, cdb_data, fu_ready,
      input  disp_ready, iss_valid, iss_op, iss_rs1, iss_rs2,
      input  iss_rd_tag, iss_rob, occupancy
   );
endinterface

// File: rtl/reservation_station.sv
// Unified issue queue: CDB wakeup, age-matrix oldest-first select,
// registered multi-port issue.
module reservation_station #(
   parameter int IQ_SIZE     = 16,
   parameter int ISSUE_PORTS = 3,
   parameter int CDB_PORTS   = 3,
   parameter int DATA_W      = 32,
   parameter int TAG_W       = 6,
   parameter int ROB_W       = 6,
   parameter int OP_W        = 5
) (
   input logic                  clk,
   input logic                  rst_n,
   reservation_station_if.slave rs
);
   localparam int IDX_W = $clog2(IQ_SIZE);
   localparam int OCC_W = $clog2(IQ_SIZE + 1);
   localparam logic [IQ_SIZE-1:0] ONE = {{(IQ_SIZE-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic              r;
      logic [DATA_W-1:0] d;
   } src_t;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [TAG_W-1:0] rd;
      logic [ROB_W-1:0] rob;
      logic [TAG_W-1:0] t1;
      logic [TAG_W-1:0] t2;
      src_t             s1;
      src_t             s2;
   } ent_t;

   logic [IQ_SIZE-1:0] valid_q, valid_d;
   ent_t               ent_q [IQ_SIZE];
   ent_t               ent_d [IQ_SIZE];
   // age_q[i][j] set: entry i was dispatched before entry j
   logic [IQ_SIZE-1:0] age_q [IQ_SIZE];
   logic [IQ_SIZE-1:0] age_d [IQ_SIZE];
   logic [OCC_W-1:0]   occ_q, occ_d;

   logic [ISSUE_PORTS-1:0]             iss_valid_q;
   logic [ISSUE_PORTS-1:0][OP_W-1:0]   iss_op_q;
   logic [ISSUE_PORTS-1:0][DATA_W-1:0] iss_rs1_q;
   logic [ISSUE_PORTS-1:0][DATA_W-1:0] iss_rs2_q;
   logic [ISSUE_PORTS-1:0][TAG_W-1:0]  iss_rd_q;
   logic [ISSUE_PORTS-1:0][ROB_W-1:0]  iss_rob_q;

   logic [CDB_PORTS-1:0]             cdb_valid;
   logic [CDB_PORTS-1:0][TAG_W-1:0]  cdb_tag;
   logic [CDB_PORTS-1:0][DATA_W-1:0] cdb_data;

   logic                               disp_ready;
   logic                               accept;
   logic [IDX_W-1:0]                   free_idx;
   logic                               free_found;
   logic [IQ_SIZE-1:0]                 elig;
   logic [IQ_SIZE-1:0]                 cand;
   logic [IQ_SIZE-1:0]                 take;
   logic [ISSUE_PORTS-1:0]             gnt;
   logic [ISSUE_PORTS-1:0][IDX_W-1:0]  gidx;
   logic [OCC_W-1:0]                   n_iss;

   assign cdb_valid = rs.cdb_valid;
   assign cdb_tag   = rs.cdb_tag;
   assign cdb_data  = rs.cdb_data;

   // Tag 0 is hard-wired ready; otherwise the lowest matching port wins.
   function automatic src_t wake(input logic [TAG_W-1:0] tag,
                                 input src_t s);
      src_t o;
      o = s;
      if (tag == '0) o.r = 1'b1;
      for (int c = 0; c < CDB_PORTS; c++) begin
         if (!o.r && cdb_valid[c] && cdb_tag[c] == tag) begin
            o.r = 1'b1;
            o.d = cdb_data[c];
         end
      end
      return o;
   endfunction

   assign disp_ready = occ_q < OCC_W'(IQ_SIZE);
   assign accept     = rs.disp_valid & disp_ready & ~rs.flush;

   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < IQ_SIZE; i++) begin
         if (!free_found && !valid_q[i]) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

   always_comb begin
      elig = '0;
      for (int i = 0; i < IQ_SIZE; i++)
         elig[i] = valid_q[i] & ent_q[i].s1.r & ent_q[i].s2.r;
   end

   always_comb begin
      cand = elig;
      gnt  = '0;
      gidx = '0;
      take = '0;
      for (int p = 0; p < ISSUE_PORTS; p++) begin
         if (rs.fu_ready[p]) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
               if (!gnt[p] && cand[i] &&
                   &(age_q[i] | ~cand | (ONE << i))) begin
                  gnt[p]  = 1'b1;
                  gidx[p] = IDX_W'(i);
                  take[i] = 1'b1;
               end
            end
            cand = cand & ~take;
         end
      end
   end

   always_comb begin
      valid_d = valid_q & ~take;
      for (int i = 0; i < IQ_SIZE; i++) begin
         age_d[i] = age_q[i];
         ent_d[i] = ent_q[i];
         if (valid_q[i]) begin
            ent_d[i].s1 = wake(ent_q[i].t1, ent_q[i].s1);
            ent_d[i].s2 = wake(ent_q[i].t2, ent_q[i].s2);
         end
      end
      if (accept) begin
         valid_d[free_idx]   = 1'b1;
         ent_d[free_idx].op  = rs.disp_op;
         ent_d[free_idx].rd  = rs.disp_rd_tag;
         ent_d[free_idx].rob = rs.disp_rob;
         ent_d[free_idx].t1  = rs.disp_rs1_tag;
         ent_d[free_idx].t2  = rs.disp_rs2_tag;
         ent_d[free_idx].s1  = wake(rs.disp_rs1_tag,
                                    {rs.disp_rs1_rdy, rs.disp_rs1_data});
         ent_d[free_idx].s2  = wake(rs.disp_rs2_tag,
                                    {rs.disp_rs2_rdy, rs.disp_rs2_data});
         age_d[free_idx] = '0;
         for (int j = 0; j < IQ_SIZE; j++)
            if (IDX_W'(j) != free_idx) age_d[j][free_idx] = 1'b1;
      end
      if (rs.flush) valid_d = '0;
   end

   always_comb begin
      n_iss = '0;
      for (int p = 0; p < ISSUE_PORTS; p++)
         n_iss = n_iss + OCC_W'(gnt[p]);
      occ_d = rs.flush ? '0 : occ_q + OCC_W'(accept) - n_iss;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         occ_q   <= '0;
         for (int i = 0; i < IQ_SIZE; i++) begin
            ent_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int i = 0; i < IQ_SIZE; i++) begin
            ent_q[i] <= ent_d[i];
            age_q[i] <= age_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid_q <= '0;
         iss_op_q    <= '0;
         iss_rs1_q   <= '0;
         iss_rs2_q   <= '0;
         iss_rd_q    <= '0;
         iss_rob_q   <= '0;
      end else begin
         iss_valid_q <= gnt & {ISSUE_PORTS{~rs.flush}};
         for (int p = 0; p < ISSUE_PORTS; p++) begin
            if (gnt[p] && !rs.flush) begin
               iss_op_q[p]  <= ent_q[gidx[p]].op;
               iss_rs1_q[p] <= ent_q[gidx[p]].s1.d;
               iss_rs2_q[p] <= ent_q[gidx[p]].s2.d;
               iss_rd_q[p]  <= ent_q[gidx[p]].rd;
               iss_rob_q[p] <= ent_q[gidx[p]].rob;
            end
         end
      end
   end

   assign rs.disp_ready = disp_ready;
   assign rs.occupancy  = occ_q;
   assign rs.iss_valid  = iss_valid_q;
   assign rs.iss_op     = iss_op_q;
   assign rs.iss_rs1    = iss_rs1_q;
   assign rs.iss_rs2    = iss_rs2_q;
   assign rs.iss_rd_tag = iss_rd_q;
   assign rs.iss_rob    = iss_rob_q;
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter IQ_SIZE, default 16: number of entries, power of two, at least 4.
REQ-002 SHALL have parameter ISSUE_PORTS, default 3: number of issue ports, one per FU.
REQ-003 SHALL have parameter CDB_PORTS, default 3: number of common data bus broadcast ports.
REQ-004 SHALL have parameters DATA_W=32, TAG_W=6, ROB_W=6 and OP_W=5, which set the operand, physical tag, ROB index and micro-op widths.
REQ-005 SHALL have ports as follows. One clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  free entry available.
- disp_op  in  OP_W  micro-op.
- disp_rd_tag  in  TAG_W  destination tag.
- disp_rob  in  ROB_W  ROB index.
- disp_rs1_tag, disp_rs2_tag  in  TAG_W  source tags.
- disp_rs1_rdy, disp_rs2_rdy  in  1  source data already valid.
- disp_rs1_data, disp_rs2_data  in  DATA_W  source data; rs2 carries the immediate when disp_rs2_rdy=1.
- cdb_valid  in  CDB_PORTS  broadcast valid.
- cdb_tag  in  CDB_PORTS*TAG_W  broadcast tags.
- cdb_data  in  CDB_PORTS*DATA_W  broadcast data.
- fu_ready  in  ISSUE_PORTS  FU p can accept an op this cycle.
- iss_valid  out  ISSUE_PORTS  issue valid.
- iss_op  out  ISSUE_PORTS*OP_W  micro-op.
- iss_rs1, iss_rs2  out  ISSUE_PORTS*DATA_W  operands.
- iss_rd_tag  out  ISSUE_PORTS*TAG_W  destination tag.
- iss_rob  out  ISSUE_PORTS*ROB_W  ROB index.
- occupancy  out  $clog2(IQ_SIZE+1)  number of valid entries.

Function
REQ-006 SHALL hold per entry: valid, op, rd_tag, rob, and for each source a tag, a ready bit and data.
REQ-007 SHALL drive disp_ready = (occupancy < IQ_SIZE), based on registered state only; entries freed in the same cycle SHALL NOT count.
REQ-008 SHALL accept a dispatch when disp_valid & disp_ready & !flush, writing the lowest-index invalid entry at the next clock edge.
REQ-009 SHALL ignore disp_valid while disp_ready=0, with no state change.
REQ-010 SHALL treat a source tag of 0 as always ready, and SHALL never capture CDB data into such a source.
REQ-011 SHALL wake up, each cycle, every valid entry whose non-ready source tag equals a valid cdb_tag: set ready and capture cdb_data at the next edge.
REQ-012 SHALL apply the same CDB match to dispatching sources (same-cycle bypass), so an operand broadcast in the dispatch cycle is not lost.
REQ-013 SHALL, when several CDB ports match one source, take the lowest-numbered port.
REQ-014 SHALL mark an entry eligible when valid and both ready bits are registered as 1; a wakeup in cycle t makes the entry eligible in cycle t+1.
REQ-015 SHALL select, for port p = 0 upward, the oldest eligible entry not taken by a lower port, and only when fu_ready[p]=1.
REQ-016 SHALL define age by dispatch order, tracked with an IQ_SIZE x IQ_SIZE age matrix; index order SHALL NOT be used.
REQ-017 SHALL register the issue outputs: an entry selected in cycle t appears on iss_* with iss_valid=1 in cycle t+1, and its valid bit clears at the same edge.
REQ-018 SHALL drive iss_valid[p]=0 in the cycle after a cycle with no grant on port p; iss_* data then holds its previous value.
REQ-019 SHALL update occupancy each cycle as previous + accepted dispatch - issued count, with no wrap.
REQ-020 SHALL, on flush, at the next edge clear all valid bits, set occupancy to 0 and clear iss_valid; the same-cycle dispatch, wakeups and selects SHALL be discarded.
REQ-021 SHALL allow dispatch into a full queue only on the cycle after a slot frees (see REQ-007).

Reset
REQ-022 SHALL, on rst_n=0, immediately and asynchronously clear all entry valid bits and the age matrix, and set iss_valid=0, occupancy=0 and disp_ready=1 (driven from occupancy=0).
REQ-023 SHALL, on rst_n=0, reset iss_* data outputs to 0.
REQ-024 SHALL, when reset asserts mid-operation, drop all in-flight entries; after release the first dispatch SHALL go to entry 0.

Verification
REQ-025 SHALL cover: dispatch with rs1_rdy=rs2_rdy=1, data 5 and 7, fu_ready=all 1 -> the entry is eligible the next cycle, iss_valid[0]=1 one cycle later with iss_rs1=5 and iss_rs2=7, and occupancy returns to 0.
REQ-026 SHALL cover: dispatch rs1_tag=9 not ready, then cdb_tag=9 with data 0xAB two cycles later -> issue occurs 2 cycles after the broadcast with iss_rs1=0xAB.
REQ-027 SHALL cover: cdb_tag=9 broadcast in the same cycle as the dispatch of rs1_tag=9 -> the operand is captured, with no further wait.
REQ-028 SHALL cover: A, B, C dispatched in order into indices 2, 0, 1, all ready, fu_ready=3'b011 -> A issues on port 0 and B on port 1, and C issues next cycle on port 0.
REQ-029 SHALL cover: fill IQ_SIZE entries -> disp_ready=0 and a further dispatch is dropped; issue one entry -> disp_ready=1 the following cycle.
REQ-030 SHALL cover: flush with 5 valid entries plus a concurrent dispatch -> occupancy=0 and iss_valid=0 next cycle; rst_n pulsed mid-run -> outputs at reset values immediately.
